// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with decode, operand bypass and load-use stall.
// One-bubble RUN/BUBBLE sequencer; flush beats hold beats hazard.
module id_ex_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] instr_i,
  output logic [4:0]  RSaddr_o,
  output logic [4:0]  RTaddr_o,
  input  logic [31:0] RSdata_i,
  input  logic [31:0] RTdata_i,
  input  logic        wb_we_i,
  input  logic [4:0]  wb_addr_i,
  input  logic [31:0] wb_data_i,
  input  logic        flush_i,
  input  logic        hold_i,
  output logic        stall_o,
  output logic        ex_valid_o,
  output logic [31:0] ex_pc_o,
  output logic [31:0] ex_rs1_o,
  output logic [31:0] ex_rs2_o,
  output logic [31:0] ex_imm_o,
  output logic [4:0]  ex_rs1_addr_o,
  output logic [4:0]  ex_rs2_addr_o,
  output logic [4:0]  ex_rd_o,
  output logic [2:0]  ex_funct3_o,
  output logic        ex_f7b5_o,
  output logic [6:0]  ex_opcode_o,
  output logic        ex_regwrite_o,
  output logic        ex_memread_o,
  output logic        ex_memwrite_o,
  output logic        ex_alusrc_o,
  output logic        ex_branch_o,
  output logic        ex_jump_o,
  output logic        ex_illegal_o
);

  typedef enum logic {S_RUN, S_BUBBLE} state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic        f7b5;
    logic [6:0]  opcode;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic        alusrc;
    logic        branch;
    logic        jump;
    logic        illegal;
  } ex_t;

  state_t r_state, w_state_nxt;
  ex_t    r_ex, w_dec, w_nxt;

  logic [6:0]  w_op;
  logic [4:0]  w_rs1a, w_rs2a, w_rd;
  logic        w_ld, w_st, w_opi, w_opr, w_br;
  logic        w_lui, w_aui, w_jal, w_jalr;
  logic        w_known, w_use_rs2, w_haz, w_stall;
  logic [31:0] w_imm, w_rs1, w_rs2;

  assign w_op   = instr_i[6:0];
  assign w_rs1a = instr_i[19:15];
  assign w_rs2a = instr_i[24:20];
  assign w_rd   = instr_i[11:7];

  assign RSaddr_o = w_rs1a;
  assign RTaddr_o = w_rs2a;

  assign w_ld   = (w_op == 7'b0000011);
  assign w_st   = (w_op == 7'b0100011);
  assign w_opi  = (w_op == 7'b0010011);
  assign w_opr  = (w_op == 7'b0110011);
  assign w_br   = (w_op == 7'b1100011);
  assign w_lui  = (w_op == 7'b0110111);
  assign w_aui  = (w_op == 7'b0010111);
  assign w_jal  = (w_op == 7'b1101111);
  assign w_jalr = (w_op == 7'b1100111);

  assign w_known = |{w_ld, w_st, w_opi, w_opr, w_br,
                     w_lui, w_aui, w_jal, w_jalr};
  assign w_use_rs2 = w_st | w_opr | w_br;

  always_comb begin
    w_imm = '0;
    unique case (1'b1)
      w_ld, w_opi, w_jalr:
        w_imm = {{20{instr_i[31]}}, instr_i[31:20]};
      w_st:
        w_imm = {{20{instr_i[31]}}, instr_i[31:25],
                 instr_i[11:7]};
      w_br:
        w_imm = {{19{instr_i[31]}}, instr_i[31],
                 instr_i[7], instr_i[30:25],
                 instr_i[11:8], 1'b0};
      w_lui, w_aui:
        w_imm = {instr_i[31:12], 12'b0};
      w_jal:
        w_imm = {{11{instr_i[31]}}, instr_i[31],
                 instr_i[19:12], instr_i[20],
                 instr_i[30:21], 1'b0};
      default: w_imm = '0;
    endcase
  end

  // Writeback of this same cycle overrides stale register-file data.
  assign w_rs1 = (wb_we_i && wb_addr_i != 5'd0 &&
                  wb_addr_i == w_rs1a) ? wb_data_i : RSdata_i;
  assign w_rs2 = (wb_we_i && wb_addr_i != 5'd0 &&
                  wb_addr_i == w_rs2a) ? wb_data_i : RTdata_i;

  always_comb begin
    w_dec          = '0;
    w_dec.valid    = 1'b1;
    w_dec.pc       = pc_i;
    w_dec.rs1      = w_rs1;
    w_dec.rs2      = w_rs2;
    w_dec.imm      = w_imm;
    w_dec.rs1_addr = w_rs1a;
    w_dec.rs2_addr = w_rs2a;
    w_dec.rd       = w_rd;
    w_dec.funct3   = instr_i[14:12];
    w_dec.f7b5     = instr_i[30];
    w_dec.opcode   = w_op;
    w_dec.regwrite = (w_ld | w_opi | w_opr | w_lui |
                      w_aui | w_jal | w_jalr) &
                     (w_rd != 5'd0);
    w_dec.memread  = w_ld;
    w_dec.memwrite = w_st;
    w_dec.alusrc   = w_ld | w_st | w_opi | w_lui |
                     w_aui | w_jalr;
    w_dec.branch   = w_br;
    w_dec.jump     = w_jal | w_jalr;
    w_dec.illegal  = ~w_known;
  end

  assign w_haz = valid_i & r_ex.valid & r_ex.memread &
                 (r_ex.rd != 5'd0) &
                 ((r_ex.rd == w_rs1a) |
                  (w_use_rs2 & (r_ex.rd == w_rs2a)));

  always_comb begin
    w_nxt       = r_ex;
    w_state_nxt = r_state;
    w_stall     = 1'b0;
    if (flush_i) begin
      w_nxt       = '0;
      w_state_nxt = S_RUN;
    end else if (hold_i) begin
      w_stall = 1'b1;
    end else if (r_state == S_RUN && w_haz) begin
      w_nxt       = '0;
      w_stall     = 1'b1;
      w_state_nxt = S_BUBBLE;
    end else begin
      w_nxt       = valid_i ? w_dec : '0;
      w_state_nxt = S_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_ex    <= '0;
      r_state <= S_RUN;
    end else begin
      r_ex    <= w_nxt;
      r_state <= w_state_nxt;
    end
  end

  assign stall_o       = w_stall;
  assign ex_valid_o    = r_ex.valid;
  assign ex_pc_o       = r_ex.pc;
  assign ex_rs1_o      = r_ex.rs1;
  assign ex_rs2_o      = r_ex.rs2;
  assign ex_imm_o      = r_ex.imm;
  assign ex_rs1_addr_o = r_ex.rs1_addr;
  assign ex_rs2_addr_o = r_ex.rs2_addr;
  assign ex_rd_o       = r_ex.rd;
  assign ex_funct3_o   = r_ex.funct3;
  assign ex_f7b5_o     = r_ex.f7b5;
  assign ex_opcode_o   = r_ex.opcode;
  assign ex_regwrite_o = r_ex.regwrite;
  assign ex_memread_o  = r_ex.memread;
  assign ex_memwrite_o = r_ex.memwrite;
  assign ex_alusrc_o   = r_ex.alusrc;
  assign ex_branch_o   = r_ex.branch;
  assign ex_jump_o     = r_ex.jump;
  assign ex_illegal_o  = r_ex.illegal;

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock for all state.
REQ-002 SHALL have: rst_n  in  1  synchronous active-high reset; sampled on rising clk only.
REQ-003 SHALL have: valid_i, pc_i, instr_i  in  1/32/32  decode-slot instruction from IF/ID.
REQ-004 SHALL have: RSaddr_o, RTaddr_o  out  5/5  register-file read addresses, combinational instr_i[19:15] and [24:20].
REQ-005 SHALL have: RSdata_i, RTdata_i  in  32/32  register-file read data, x0 already forced to 0.
REQ-006 SHALL have: wb_we_i, wb_addr_i, wb_data_i  in  1/5/32  writeback port, same values driven to the register file.
REQ-007 SHALL have: flush_i  in  1  branch/jump redirect from EX; hold_i  in  1  downstream back-pressure.
REQ-008 SHALL have: stall_o  out  1  combinational; IF/ID SHALL keep its contents when high.
REQ-009 SHALL have registered outputs: ex_valid_o 1, ex_pc_o 32, ex_rs1_o 32, ex_rs2_o 32, ex_imm_o 32, ex_rs1_addr_o 5, ex_rs2_addr_o 5, ex_rd_o 5, ex_funct3_o 3, ex_f7b5_o 1, ex_opcode_o 7.
REQ-010 SHALL have registered control outputs, 1 bit each: ex_regwrite_o, ex_memread_o, ex_memwrite_o, ex_alusrc_o, ex_branch_o, ex_jump_o, ex_illegal_o.

Function
REQ-011 Decode SHALL support opcodes LOAD 0000011, STORE 0100011, OP-IMM 0010011, OP 0110011, BRANCH 1100011, LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111.
REQ-012 Immediate SHALL be sign-extended per type I/S/B/U/J; B and J include bit0=0; U = instr[31:12]<<12; OP and unknown give 0.
REQ-013 regwrite SHALL be 1 for LOAD, OP-IMM, OP, LUI, AUIPC, JAL, JALR, and forced 0 when rd=0.
REQ-014 memread=LOAD; memwrite=STORE; alusrc=1 for LOAD, STORE, OP-IMM, LUI, AUIPC, JALR; branch=BRANCH; jump=JAL or JALR.
REQ-015 Unknown opcode SHALL set ex_illegal_o=1 with all other controls 0, ex_valid_o following the slot.
REQ-016 Operand bypass: if wb_we_i=1, wb_addr_i!=0 and wb_addr_i equals the source address, the captured operand SHALL be wb_data_i, else RSdata_i/RTdata_i.
REQ-017 Load-use hazard SHALL be: valid_i=1, ex_valid_o=1, ex_memread_o=1, ex_rd_o!=0, and ex_rd_o equals rs1 or rs2 of instr_i (rs2 only for STORE, OP, BRANCH).
REQ-018 FSM SHALL have states RUN and BUBBLE; reset enters RUN.
REQ-019 RUN with hazard and no flush/hold SHALL capture a bubble (all ex_* outputs zero), assert stall_o, and go to BUBBLE.
REQ-020 BUBBLE SHALL deassert stall_o, capture the held instruction normally, and return to RUN; total added latency is exactly 1 cycle.
REQ-021 Normal capture latency SHALL be 1 clk: decode-slot values appear on ex_* after the next rising edge.
REQ-022 hold_i=1 SHALL freeze all ex_* registers and FSM state, and SHALL assert stall_o.
REQ-023 flush_i=1 SHALL capture a bubble, deassert stall_o, and force RUN; flush_i SHALL win over hold_i and hazard.
REQ-024 valid_i=0 SHALL capture a bubble; hazard detection SHALL ignore the slot.
REQ-025 Precedence SHALL be rst_n > flush_i > hold_i > hazard > normal capture.

Reset
REQ-026 rst_n=1 at a rising edge SHALL zero every ex_* output, set state RUN, and leave stall_o=0 the following cycle.
REQ-027 Reset asserted mid-BUBBLE SHALL discard the pending instruction; no ex_valid_o pulse SHALL follow until new valid_i.
REQ-028 Outputs SHALL be undefined-free after the first reset edge; no asynchronous reset path SHALL exist.

Verification
REQ-029 Capture: addi x5,x1,-4 (0xFFC08293), RSdata_i=10 -> next cycle ex_imm_o=0xFFFFFFFC, ex_rs1_o=10, ex_rd_o=5, regwrite=1, alusrc=1.
REQ-030 Load-use: lw x3,0(x2) then add x4,x3,x1 -> stall_o=1 for one cycle, one bubble on ex_valid_o, add issued the cycle after.
REQ-031 Bypass: wb_we_i=1, wb_addr_i=7, wb_data_i=0x55, RSdata_i=0x11, rs1=7 -> ex_rs1_o=0x55; same stimulus with wb_addr_i=0 -> 0x11.
REQ-032 Flush vs hold: flush_i=1 and hold_i=1 together -> ex_valid_o=0, stall_o=0, state RUN.
REQ-033 Hold: hold_i=1 for 3 cycles -> ex_* unchanged, stall_o=1 for 3 cycles, then normal capture.
REQ-034 Illegal and x0: opcode 0x7F -> ex_illegal_o=1, other controls 0; OP with rd=0 -> regwrite=0; synchronous reset mid-stall -> all ex_*=0.
